// File: rtl/debounce_botoes.sv
// debounce_botoes: N-channel push-button conditioner.
// Each raw input is synchronised, debounced by its own FSM, and turned into a
// clean level plus one-cycle press / release / long-press pulses.

// debounce_canal: synchroniser, debounce FSM and pulse generation for one button.
module debounce_canal #(
  parameter int DB_CICLOS   = 5,
  parameter int LONG_CICLOS = 20,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic botao,
  output logic estado_nxt,
  output logic estado_db,
  output logic pulso_aperto,
  output logic pulso_soltura,
  output logic pulso_longo
);

  typedef enum logic [1:0] {SOLTO, DB_APERTA, APERTADO, DB_SOLTA} est_t;

  localparam logic [CNT_W-1:0] DB_C = CNT_W'(DB_CICLOS);
  localparam logic [CNT_W-1:0] LG_C = CNT_W'(LONG_CICLOS);
  localparam logic [CNT_W-1:0] UM   = CNT_W'(1);

  logic [1:0]       sync_pipe;
  logic             s;
  est_t             est_q, est_n;
  logic [CNT_W-1:0] cnt_db_q, cnt_db_n;
  logic [CNT_W-1:0] cnt_long_q, cnt_long_n, long_inc;
  logic             ativo_q;
  logic             aperto_nxt, soltura_nxt, longo_nxt;

  assign s = sync_pipe[1];

  // Two-flop synchroniser; the FSM only ever looks at the second stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], botao};
  end

  // State, counters and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      est_q         <= SOLTO;
      cnt_db_q      <= '0;
      cnt_long_q    <= '0;
      estado_db     <= 1'b0;
      pulso_aperto  <= 1'b0;
      pulso_soltura <= 1'b0;
      pulso_longo   <= 1'b0;
    end else begin
      est_q         <= est_n;
      cnt_db_q      <= cnt_db_n;
      cnt_long_q    <= cnt_long_n;
      estado_db     <= estado_nxt;
      pulso_aperto  <= aperto_nxt;
      pulso_soltura <= soltura_nxt;
      pulso_longo   <= longo_nxt;
    end
  end

  // Press-duration counter saturates at LONG_CICLOS; it is frozen at 0 when disabled.
  assign long_inc = (LONG_CICLOS == 0 || cnt_long_q == LG_C) ? cnt_long_q : cnt_long_q + UM;

  // Next state and counters.
  always_comb begin
    est_n      = est_q;
    cnt_db_n   = cnt_db_q;
    cnt_long_n = cnt_long_q;
    case (est_q)
      SOLTO: begin
        if (s) begin
          if (DB_CICLOS == 1) begin
            est_n      = APERTADO;
            cnt_db_n   = '0;
            cnt_long_n = '0;
          end else begin
            est_n    = DB_APERTA;
            cnt_db_n = UM;
          end
        end
      end
      DB_APERTA: begin
        if (!s) begin
          est_n    = SOLTO;
          cnt_db_n = '0;
        end else if (cnt_db_q + UM == DB_C) begin
          est_n      = APERTADO;
          cnt_db_n   = '0;
          cnt_long_n = '0;
        end else begin
          cnt_db_n = cnt_db_q + UM;
        end
      end
      APERTADO: begin
        cnt_long_n = long_inc;
        if (!s) begin
          if (DB_CICLOS == 1) begin
            est_n    = SOLTO;
            cnt_db_n = '0;
          end else begin
            est_n    = DB_SOLTA;
            cnt_db_n = UM;
          end
        end
      end
      DB_SOLTA: begin
        // Still logically pressed here, so the long-press timer keeps running.
        cnt_long_n = long_inc;
        if (s) begin
          est_n    = APERTADO;
          cnt_db_n = '0;
        end else if (cnt_db_q + UM == DB_C) begin
          est_n    = SOLTO;
          cnt_db_n = '0;
        end else begin
          cnt_db_n = cnt_db_q + UM;
        end
      end
      default: begin
        est_n    = SOLTO;
        cnt_db_n = '0;
      end
    endcase
  end

  // Next output values: level from the next state, pulses from level edges and timer hit.
  always_comb begin
    ativo_q     = (est_q == APERTADO) || (est_q == DB_SOLTA);
    estado_nxt  = (est_n == APERTADO) || (est_n == DB_SOLTA);
    aperto_nxt  = estado_nxt & ~ativo_q;
    soltura_nxt = ~estado_nxt & ativo_q;
    longo_nxt   = (LONG_CICLOS != 0) && ativo_q &&
                  (cnt_long_q != LG_C) && (cnt_long_n == LG_C);
  end

endmodule

// debounce_botoes: array of independent channels plus the registered "any pressed" flag.
module debounce_botoes #(
  parameter int N_CANAIS    = 4,
  parameter int DB_CICLOS   = 5,
  parameter int LONG_CICLOS = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CANAIS-1:0] botoes,
  output logic [N_CANAIS-1:0] estado_db,
  output logic [N_CANAIS-1:0] pulso_aperto,
  output logic [N_CANAIS-1:0] pulso_soltura,
  output logic [N_CANAIS-1:0] pulso_longo,
  output logic                algum_apertado
);

  localparam int MAX_C = (DB_CICLOS > LONG_CICLOS) ? DB_CICLOS : LONG_CICLOS;
  localparam int CNT_W = $clog2(MAX_C + 1);

  logic [N_CANAIS-1:0] estado_nxt;

  for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
    debounce_canal #(
      .DB_CICLOS  (DB_CICLOS),
      .LONG_CICLOS(LONG_CICLOS),
      .CNT_W      (CNT_W)
    ) u_canal (
      .clk          (clk),
      .rst_n        (rst_n),
      .botao        (botoes[i]),
      .estado_nxt   (estado_nxt[i]),
      .estado_db    (estado_db[i]),
      .pulso_aperto (pulso_aperto[i]),
      .pulso_soltura(pulso_soltura[i]),
      .pulso_longo  (pulso_longo[i])
    );
  end

  // Built from the channels' next levels so it updates on the same edge as estado_db.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) algum_apertado <= 1'b0;
    else        algum_apertado <= |estado_nxt;
  end

endmodule

// File: tb/tb_debounce_botoes.sv
// Bench for debounce_botoes with default parameters: table of single-shot
// stimulus records with hand-derived pulse edges, plus a reset-mid-press sequence.
module tb_debounce_botoes;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] botoes;
  logic [N-1:0] estado_db, pulso_aperto, pulso_soltura, pulso_longo;
  logic         algum_apertado;

  int checks   = 0;
  int failures = 0;

  debounce_botoes #(.N_CANAIS(N), .DB_CICLOS(5), .LONG_CICLOS(20)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .botoes        (botoes),
    .estado_db     (estado_db),
    .pulso_aperto  (pulso_aperto),
    .pulso_soltura (pulso_soltura),
    .pulso_longo   (pulso_longo),
    .algum_apertado(algum_apertado)
  );

  always #5 clk = ~clk;

  // Edge numbers: edge 0 is the first posedge that samples the new raw level;
  // an exp_* of -1 means that pulse must never appear.
  typedef struct {
    string        name;
    logic [N-1:0] mask;
    int           on_len;
    int           period;
    int           gap_start;
    int           gap_len;
    int           total;
    int           exp_ap;
    int           exp_so;
    int           exp_lo;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic raw_at(input vec_t v, input int e);
    if (e >= v.on_len) return 1'b0;
    if (v.period > 0 && ((e / v.period) % 2) != 0) return 1'b0;
    if (v.gap_len > 0 && e >= v.gap_start && e < v.gap_start + v.gap_len) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk_zero(input string nm);
    chk({nm, " estado"},  32'(estado_db),      32'd0);
    chk({nm, " aperto"},  32'(pulso_aperto),   32'd0);
    chk({nm, " soltura"}, 32'(pulso_soltura),  32'd0);
    chk({nm, " longo"},   32'(pulso_longo),    32'd0);
    chk({nm, " algum"},   32'(algum_apertado), 32'd0);
  endtask

  task automatic do_reset();
    botoes = '0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [N-1:0] e_est, e_ap, e_so, e_lo;
    do_reset();
    for (int e = 0; e < v.total; e++) begin
      botoes = raw_at(v, e) ? v.mask : '0;
      @(posedge clk);
      #1;
      e_est = (v.exp_ap >= 0 && e >= v.exp_ap && (v.exp_so < 0 || e < v.exp_so)) ? v.mask : '0;
      e_ap  = (e == v.exp_ap) ? v.mask : '0;
      e_so  = (e == v.exp_so) ? v.mask : '0;
      e_lo  = (e == v.exp_lo) ? v.mask : '0;
      chk($sformatf("%s e%0d estado", v.name, e),  32'(estado_db),      32'(e_est));
      chk($sformatf("%s e%0d aperto", v.name, e),  32'(pulso_aperto),   32'(e_ap));
      chk($sformatf("%s e%0d soltura", v.name, e), 32'(pulso_soltura),  32'(e_so));
      chk($sformatf("%s e%0d longo", v.name, e),   32'(pulso_longo),    32'(e_lo));
      chk($sformatf("%s e%0d algum", v.name, e),   32'(algum_apertado), 32'(|e_est));
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    botoes = '0;

    //          name            mask     on  per gs  gl tot ap  so  lo
    vt[0] = '{"held_ch0",      4'b0001, 40, 0, -1, 0, 50, 6, 46, 26};
    vt[1] = '{"toggle_ch1",    4'b0010, 30, 2, -1, 0, 40, -1, -1, -1};
    vt[2] = '{"bounce_ch2",    4'b0100, 40, 0, 10, 3, 50, 6, 46, 26};
    vt[3] = '{"short10_ch3",   4'b1000, 10, 0, -1, 0, 30, 6, 16, -1};
    vt[4] = '{"dual_ch0_ch3",  4'b1001, 40, 0, -1, 0, 50, 6, 46, 26};
    vt[5] = '{"exact_db_ch1",  4'b0010,  5, 0, -1, 0, 20, 6, 11, -1};
    vt[6] = '{"db_minus1_ch2", 4'b0100,  4, 0, -1, 0, 20, -1, -1, -1};
    vt[7] = '{"rel_at_long",   4'b0001, 20, 0, -1, 0, 35, 6, 26, 26};
    vt[8] = '{"rel_before_lg", 4'b1000, 19, 0, -1, 0, 35, 6, 25, -1};

    foreach (vt[k]) run_vec(vt[k]);

    // Reset in the middle of an accepted press, raw level kept high throughout.
    do_reset();
    botoes = 4'b0001;
    for (int e = 0; e <= 10; e++) begin
      @(posedge clk);
      #1;
    end
    chk("rstmid pre estado", 32'(estado_db), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_zero("rstmid async");
    @(posedge clk);
    #1;
    chk_zero("rstmid held");
    rst_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rstmid e%0d aperto", e),  32'(pulso_aperto),  32'((e == 6) ? 1 : 0));
      chk($sformatf("rstmid e%0d estado", e),  32'(estado_db),     32'((e >= 6) ? 1 : 0));
      chk($sformatf("rstmid e%0d soltura", e), 32'(pulso_soltura), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
